// File: rtl/snake_frame_renderer.sv
// Snake game pixel renderer: double-buffered rectangle table swapped at frame start,
// plus a two-register colour pipeline. Define SNAKE_RENDER_FLASH_EN for game-over flashing.
module snake_frame_renderer #(
  parameter int CW       = 10,
  parameter int MAX_BODY = 16,
  parameter int MAX_OBST = 32,
  parameter int X_LEFT   = 16,
  parameter int Y_BOTTOM = 16,
  parameter int PF_W     = 592,
  parameter int PF_H     = 432,
  parameter int V_TOTAL  = 480
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [CW-1:0]   i_pos_h,
  input  logic [CW-1:0]   i_pos_v,
  input  logic            i_blank,
  input  logic            i_frame_start,
  input  logic            i_endgame,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [1:0]      i_wr_sel,
  input  logic [5:0]      i_wr_idx,
  input  logic [4*CW-1:0] i_wr_data,
  input  logic            i_commit,
  input  logic [5:0]      i_body_len,
  input  logic [5:0]      i_obst_len,
  output logic            o_commit_pend,
  output logic            o_wr_err,
  output logic            o_red,
  output logic            o_green,
  output logic            o_blue
);
  // state   | meaning
  // ST_IDLE | shadow bank open for writes and commit
  // ST_PEND | commit latched, waiting for frame_start to swap banks
  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  localparam int RW  = 4 * CW;
  localparam int CW1 = CW + 1;
  localparam int BW  = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
  localparam int OW  = (MAX_OBST > 1) ? $clog2(MAX_OBST) : 1;
  localparam logic [5:0]    LP_BMAX = 6'(MAX_BODY);
  localparam logic [5:0]    LP_OMAX = 6'(MAX_OBST);
  localparam logic [CW-1:0] LP_VT   = CW'(V_TOTAL);
  localparam logic [CW:0]   LP_X_LO = CW1'(X_LEFT);
  localparam logic [CW:0]   LP_X_HI = CW1'(X_LEFT + PF_W);
  localparam logic [CW:0]   LP_Y_LO = CW1'(Y_BOTTOM);
  localparam logic [CW:0]   LP_Y_HI = CW1'(Y_BOTTOM + PF_H);

  state_t r_state, w_state_nxt;
  logic [RW-1:0] r_sh_head, r_sh_food, r_ac_head, r_ac_food;
  logic [RW-1:0] r_sh_body [MAX_BODY];
  logic [RW-1:0] r_ac_body [MAX_BODY];
  logic [RW-1:0] r_sh_obst [MAX_OBST];
  logic [RW-1:0] r_ac_obst [MAX_OBST];
  logic [5:0]    r_sh_blen, r_sh_olen, r_ac_blen, r_ac_olen;
  logic [RW-1:0] w_sh_head_nxt, w_sh_food_nxt;
  logic [RW-1:0] w_sh_body_nxt [MAX_BODY];
  logic [RW-1:0] w_sh_obst_nxt [MAX_OBST];
  logic [5:0]    w_sh_blen_nxt, w_sh_olen_nxt;
  logic          w_wr_fire, w_commit_fire, w_swap, w_idx_bad, r_wr_err;
  logic [CW-1:0] r_x, r_y;
  logic          r_blank, w_fence, w_flash;
  logic          w_hit_head, w_hit_food, w_hit_body, w_hit_obst;
  logic [2:0]    w_rgb, r_rgb;

  assign w_wr_fire     = i_wr_valid && o_wr_ready;
  assign w_commit_fire = i_commit && (r_state == ST_IDLE) && !i_endgame;
  // A commit arriving together with frame_start swaps immediately.
  assign w_swap        = i_frame_start && !i_endgame && ((r_state == ST_PEND) || w_commit_fire);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_commit_fire && !w_swap) w_state_nxt = ST_PEND;
      ST_PEND: if (w_swap) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wr_ready    = 1'b0;
    o_commit_pend = 1'b0;
    case (r_state)
      ST_IDLE: o_wr_ready    = 1'b1;
      ST_PEND: o_commit_pend = 1'b1;
      default: o_wr_ready    = 1'b0;
    endcase
  end

  // Shadow bank with this cycle's write and commit folded in; a swap copies this view.
  always_comb begin
    w_sh_head_nxt = r_sh_head;
    w_sh_food_nxt = r_sh_food;
    w_sh_body_nxt = r_sh_body;
    w_sh_obst_nxt = r_sh_obst;
    w_sh_blen_nxt = r_sh_blen;
    w_sh_olen_nxt = r_sh_olen;
    w_idx_bad     = 1'b0;
    if (w_wr_fire) begin
      case (i_wr_sel)
        2'd0: w_sh_head_nxt = i_wr_data;
        2'd1: w_sh_food_nxt = i_wr_data;
        2'd2: if (i_wr_idx < LP_BMAX) w_sh_body_nxt[i_wr_idx[BW-1:0]] = i_wr_data;
              else w_idx_bad = 1'b1;
        default: if (i_wr_idx < LP_OMAX) w_sh_obst_nxt[i_wr_idx[OW-1:0]] = i_wr_data;
                 else w_idx_bad = 1'b1;
      endcase
    end
    if (w_commit_fire) begin
      w_sh_blen_nxt = (i_body_len > LP_BMAX) ? LP_BMAX : i_body_len;
      w_sh_olen_nxt = (i_obst_len > LP_OMAX) ? LP_OMAX : i_obst_len;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_head <= '0;
      r_sh_food <= '0;
      r_ac_head <= '0;
      r_ac_food <= '0;
      r_sh_blen <= '0;
      r_sh_olen <= '0;
      r_ac_blen <= '0;
      r_ac_olen <= '0;
      r_wr_err  <= 1'b0;
      for (int i = 0; i < MAX_BODY; i++) begin
        r_sh_body[i] <= '0;
        r_ac_body[i] <= '0;
      end
      for (int i = 0; i < MAX_OBST; i++) begin
        r_sh_obst[i] <= '0;
        r_ac_obst[i] <= '0;
      end
    end else begin
      r_sh_head <= w_sh_head_nxt;
      r_sh_food <= w_sh_food_nxt;
      r_sh_body <= w_sh_body_nxt;
      r_sh_obst <= w_sh_obst_nxt;
      r_sh_blen <= w_sh_blen_nxt;
      r_sh_olen <= w_sh_olen_nxt;
      r_wr_err  <= w_idx_bad;
      if (w_swap) begin
        r_ac_head <= w_sh_head_nxt;
        r_ac_food <= w_sh_food_nxt;
        r_ac_body <= w_sh_body_nxt;
        r_ac_obst <= w_sh_obst_nxt;
        r_ac_blen <= w_sh_blen_nxt;
        r_ac_olen <= w_sh_olen_nxt;
      end
    end
  end

  assign o_wr_err = r_wr_err;

`ifdef SNAKE_RENDER_FLASH_EN
  logic [7:0] r_frame_cnt;
  logic       r_endgame_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
      r_endgame_d <= 1'b0;
    end else begin
      r_endgame_d <= i_endgame;
      if (i_endgame && !r_endgame_d) r_frame_cnt <= '0;
      else if (i_frame_start)        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end
  assign w_flash = i_endgame && r_frame_cnt[4];
`else
  assign w_flash = 1'b0;
`endif

  // Rect layout {w,h,x,y}; end coordinates use CW+1 bits so they never wrap.
  function automatic logic f_hit(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                 input logic [RW-1:0] r);
    logic [CW:0] x_end, y_end;
    x_end = {1'b0, r[CW +: CW]} + {1'b0, r[3*CW +: CW]};
    y_end = {1'b0, r[0 +: CW]}  + {1'b0, r[2*CW +: CW]};
    return (px >= r[CW +: CW]) && ({1'b0, px} < x_end) &&
           (py >= r[0 +: CW])  && ({1'b0, py} < y_end);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_blank <= 1'b1;
      r_rgb   <= 3'b000;
    end else begin
      r_x     <= i_pos_h;
      r_y     <= LP_VT - i_pos_v;
      r_blank <= i_blank;
      r_rgb   <= w_rgb;
    end
  end

  always_comb begin
    w_hit_head = f_hit(r_x, r_y, r_ac_head);
    w_hit_food = f_hit(r_x, r_y, r_ac_food);
    w_hit_body = 1'b0;
    w_hit_obst = 1'b0;
    for (int i = 0; i < MAX_BODY; i++)
      if ((6'(i) < r_ac_blen) && f_hit(r_x, r_y, r_ac_body[i])) w_hit_body = 1'b1;
    for (int i = 0; i < MAX_OBST; i++)
      if ((6'(i) < r_ac_olen) && f_hit(r_x, r_y, r_ac_obst[i])) w_hit_obst = 1'b1;
    w_fence = !(({1'b0, r_x} >= LP_X_LO) && ({1'b0, r_x} < LP_X_HI) &&
                ({1'b0, r_y} >= LP_Y_LO) && ({1'b0, r_y} < LP_Y_HI));
  end

  always_comb begin
    w_rgb = 3'b000;
    if (r_blank)         w_rgb = 3'b000;
    else if (w_fence)    w_rgb = 3'b001;
    else if (w_hit_head) w_rgb = w_flash ? 3'b100 : 3'b110;
    else if (w_hit_body) w_rgb = w_flash ? 3'b100 : 3'b010;
    else if (w_hit_food) w_rgb = 3'b100;
    else if (w_hit_obst) w_rgb = 3'b101;
  end

  assign o_red   = r_rgb[2];
  assign o_green = r_rgb[1];
  assign o_blue  = r_rgb[0];
endmodule

// File: tb/tb_snake_frame_renderer.sv
// Directed and randomized bench for snake_frame_renderer against a rectangle-list model.
module tb_snake_frame_renderer;
  typedef struct {int x; int y; int w; int h;} rect_t;

`ifdef SNAKE_RENDER_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] pos_h = '0, pos_v = '0;
  logic blank = 1'b0, frame_start = 1'b0, endgame = 1'b0;
  logic wr_valid = 1'b0, commit = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [5:0] wr_idx = '0, body_len = '0, obst_len = '0;
  logic [39:0] wr_data = '0;
  logic wr_ready, commit_pend, wr_err, red, green, blue;

  int n_cmp = 0, n_err = 0;
  rect_t m_sh_head, m_sh_food, m_ac_head, m_ac_food;
  rect_t m_sh_body[16], m_ac_body[16], m_sh_obst[32], m_ac_obst[32];
  int m_sh_blen, m_sh_olen, m_ac_blen, m_ac_olen;
  bit m_pend, m_eg;
  logic [7:0] m_fc;

  snake_frame_renderer dut (
    .i_clk(clk), .i_rst(rst), .i_pos_h(pos_h), .i_pos_v(pos_v), .i_blank(blank),
    .i_frame_start(frame_start), .i_endgame(endgame), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready), .i_wr_sel(wr_sel), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
    .i_commit(commit), .i_body_len(body_len), .i_obst_len(obst_len),
    .o_commit_pend(commit_pend), .o_wr_err(wr_err),
    .o_red(red), .o_green(green), .o_blue(blue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [2:0] obs, input logic [2:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic rect_t mk(int x, int y, int w, int h);
    rect_t r;
    r.x = x; r.y = y; r.w = w; r.h = h;
    return r;
  endfunction

  function automatic logic [39:0] pack(rect_t r);
    return {10'(r.w), 10'(r.h), 10'(r.x), 10'(r.y)};
  endfunction

  function automatic bit inside_r(int x, int y, rect_t r);
    return x >= r.x && x < r.x + r.w && y >= r.y && y < r.y + r.h;
  endfunction

  function automatic logic [2:0] model_rgb(int h, int v, bit b);
    int x, y;
    bit hb, ho, fl;
    x = h;
    y = (480 - v) % 1024;
    if (y < 0) y += 1024;
    if (b) return 3'b000;
    if (!(x >= 16 && x < 608 && y >= 16 && y < 448)) return 3'b001;
    fl = FLASH && m_eg && m_fc[4];
    hb = 0; ho = 0;
    for (int i = 0; i < m_ac_blen; i++) if (inside_r(x, y, m_ac_body[i])) hb = 1;
    for (int i = 0; i < m_ac_olen; i++) if (inside_r(x, y, m_ac_obst[i])) ho = 1;
    if (inside_r(x, y, m_ac_head)) return fl ? 3'b100 : 3'b110;
    if (hb) return fl ? 3'b100 : 3'b010;
    if (inside_r(x, y, m_ac_food)) return 3'b100;
    if (ho) return 3'b101;
    return 3'b000;
  endfunction

  task automatic model_reset();
    rect_t z;
    z = mk(0, 0, 0, 0);
    m_sh_head = z; m_sh_food = z; m_ac_head = z; m_ac_food = z;
    foreach (m_sh_body[i]) begin m_sh_body[i] = z; m_ac_body[i] = z; end
    foreach (m_sh_obst[i]) begin m_sh_obst[i] = z; m_ac_obst[i] = z; end
    m_sh_blen = 0; m_sh_olen = 0; m_ac_blen = 0; m_ac_olen = 0;
    m_pend = 0; m_fc = '0;
  endtask

  // One clock with any mix of write / commit / frame_start, then handshake checks.
  task automatic drive(input bit wv, input int sel, input int idx, input rect_t r,
                       input bit cm, input int bl, input int ol, input bit fs);
    logic exp_err;
    exp_err = 1'b0;
    wr_valid = wv; wr_sel = 2'(sel); wr_idx = 6'(idx); wr_data = pack(r);
    commit = cm; body_len = 6'(bl); obst_len = 6'(ol); frame_start = fs;
    if (wv && !m_pend) begin
      case (sel)
        0: m_sh_head = r;
        1: m_sh_food = r;
        2: if (idx < 16) m_sh_body[idx] = r; else exp_err = 1'b1;
        default: if (idx < 32) m_sh_obst[idx] = r; else exp_err = 1'b1;
      endcase
    end
    if (cm && !m_pend && !m_eg) begin
      m_pend = 1;
      m_sh_blen = (bl > 16) ? 16 : bl;
      m_sh_olen = (ol > 32) ? 32 : ol;
    end
    if (fs) begin
      m_fc = m_fc + 8'd1;
      if (m_pend && !m_eg) begin
        m_ac_head = m_sh_head; m_ac_food = m_sh_food;
        m_ac_body = m_sh_body; m_ac_obst = m_sh_obst;
        m_ac_blen = m_sh_blen; m_ac_olen = m_sh_olen;
        m_pend = 0;
      end
    end
    tick();
    wr_valid = 0; commit = 0; frame_start = 0;
    check({2'b0, wr_err}, {2'b0, exp_err}, "wr_err");
    check({2'b0, commit_pend}, {2'b0, m_pend}, "commit_pend");
    check({2'b0, wr_ready}, {2'b0, !m_pend}, "wr_ready");
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 0);
  endtask

  task automatic check_pixel(input int h, input int v, input bit b, input string tag);
    pos_h = 10'(h); pos_v = 10'(v); blank = b;
    tick();
    tick();
    check({red, green, blue}, model_rgb(h & 1023, v & 1023, b), tag);
  endtask

  task automatic set_eg(input bit e);
    if (e && !m_eg) m_fc = '0;
    m_eg = e;
    endgame = e;
    tick();
  endtask

  function automatic rect_t rand_rect();
    rect_t r;
    r.x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 640));
    r.y = int'($urandom_range(0, 470));
    r.w = int'($urandom_range(0, 48));
    r.h = int'($urandom_range(0, 48));
    return r;
  endfunction

  initial begin
    rect_t r;
    int sel, idx, px, py;
    model_reset();
    m_eg = 0;

    // reset state
    tick();
    tick();
    check({red, green, blue}, 3'b000, "reset_rgb");
    check({2'b0, wr_ready}, 3'b001, "reset_wr_ready");
    check({2'b0, commit_pend}, 3'b000, "reset_commit_pend");
    check({2'b0, wr_err}, 3'b000, "reset_wr_err");
    rst = 0;
    tick();
    check_pixel(300, 180, 0, "bg_empty");
    check_pixel(5, 180, 0, "fence_left");
    check_pixel(300, 180, 1, "blank");

    // head rectangle, edges
    drive(1, 0, 0, mk(100, 100, 16, 16), 0, 0, 0, 0);
    drive(0, 0, 0, mk(0, 0, 0, 0), 1, 0, 0, 0);
    idle_cycle();
    drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 1);
    check_pixel(108, 372, 0, "head_mid");
    check_pixel(116, 372, 0, "head_right_excl");
    check_pixel(100, 380, 0, "head_corner");
    check_pixel(108, 364, 0, "head_top_excl");

    // body length gating and out-of-range indices
    drive(1, 2, 0, mk(200, 200, 8, 8), 0, 0, 0, 0);
    drive(1, 2, 1, mk(220, 200, 8, 8), 0, 0, 0, 0);
    drive(1, 2, 5, mk(300, 300, 8, 8), 0, 0, 0, 0);
    drive(1, 3, 31, mk(400, 100, 10, 10), 1, 2, 32, 0);
    drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 1);
    check_pixel(204, 276, 0, "body_slot0");
    check_pixel(224, 276, 0, "body_slot1");
    check_pixel(304, 176, 0, "body_slot5_hidden");
    check_pixel(405, 375, 0, "obst_slot31");
    drive(1, 2, 40, mk(500, 300, 8, 8), 0, 0, 0, 0);
    idle_cycle();
    drive(1, 3, 32, mk(500, 350, 8, 8), 0, 0, 0, 0);
    drive(0, 0, 0, mk(0, 0, 0, 0), 1, 63, 63, 1);
    check_pixel(504, 176, 0, "bad_body_dropped");
    check_pixel(504, 126, 0, "bad_obst_dropped");
    check_pixel(304, 176, 0, "body_slot5_clamped_len");

    // commit held pending for 200 cycles
    drive(1, 0, 0, mk(150, 150, 16, 16), 0, 0, 0, 0);
    pos_h = 10'd108; pos_v = 10'd372; blank = 0;
    tick();
    tick();
    drive(0, 0, 0, mk(0, 0, 0, 0), 1, 16, 32, 0);
    for (int i = 1; i < 200; i++) begin
      if (i == 50)      drive(1, 1, 0, mk(100, 100, 16, 16), 0, 0, 0, 0);
      else if (i == 80) drive(0, 0, 0, mk(0, 0, 0, 0), 1, 0, 0, 0);
      else              idle_cycle();
      check({red, green, blue}, model_rgb(108, 372, 0), "old_picture_pending");
    end
    drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 1);
    check_pixel(108, 372, 0, "after_swap_old_spot");
    check_pixel(158, 322, 0, "after_swap_new_head");

    // overlap priority, same-cycle write+commit+frame_start, wrap-around rect
    drive(1, 1, 0, mk(150, 150, 32, 32), 1, 0, 1, 1);
    check_pixel(158, 322, 0, "head_over_food");
    check_pixel(175, 305, 0, "food_only");
    drive(1, 3, 0, mk(1016, 100, 16, 16), 1, 0, 1, 1);
    check_pixel(0, 372, 0, "wrap_rect_x0");
    check_pixel(20, 372, 0, "wrap_rect_x20");
    check_pixel(300, 490, 0, "y_wrap_fence");

    // randomized tables and pixels
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        sel = int'($urandom_range(0, 3));
        idx = (sel == 2) ? int'($urandom_range(0, 19)) : int'($urandom_range(0, 35));
        drive(1, sel, idx, rand_rect(), 0, 0, 0, 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(0, 0, 0, mk(0, 0, 0, 0), 1, int'($urandom_range(0, 20)), int'($urandom_range(0, 36)), 1);
      end else begin
        drive(0, 0, 0, mk(0, 0, 0, 0), 1, int'($urandom_range(0, 20)), int'($urandom_range(0, 36)), 0);
        drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 1);
      end
      for (int p = 0; p < 6; p++) begin
        case ($urandom_range(0, 4))
          0: r = m_ac_head;
          1: r = m_ac_food;
          2: r = m_ac_body[$urandom_range(0, 15)];
          3: r = m_ac_obst[$urandom_range(0, 31)];
          default: r = mk(int'($urandom_range(0, 639)), int'($urandom_range(0, 1023)), 1, 1);
        endcase
        px = r.x + int'($urandom_range(0, 16));
        py = r.y + int'($urandom_range(0, 16));
        check_pixel(px, 480 - py, ($urandom_range(0, 7) == 0), "rand_pixel");
      end
    end

    // game over: frozen table, optional flashing
    drive(1, 0, 0, mk(300, 300, 16, 16), 1, 0, 0, 1);
    set_eg(1);
    drive(1, 0, 0, mk(400, 300, 16, 16), 0, 0, 0, 0);
    drive(0, 0, 0, mk(0, 0, 0, 0), 1, 0, 0, 0);
    check_pixel(308, 172, 0, "endgame_head");
    for (int f = 0; f < 64; f++) begin
      drive(0, 0, 0, mk(0, 0, 0, 0), 0, 0, 0, 1);
      check_pixel(308, 172, 0, "endgame_flash");
    end
    check_pixel(408, 172, 0, "endgame_commit_ignored");
    set_eg(0);

    // reset in the middle of a visible head pixel
    drive(1, 0, 0, mk(300, 300, 16, 16), 1, 0, 0, 1);
    check_pixel(308, 172, 0, "pre_reset_head");
    #2;
    rst = 1;
    #1;
    check({red, green, blue}, 3'b000, "async_reset_rgb");
    model_reset();
    tick();
    rst = 0;
    check_pixel(308, 172, 0, "post_reset_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
